// File: rtl/bakery_service_ctrl_if.sv
// Customer-side and display-side signals of the bakery service controller.
// The controller takes the slave view; whoever drives buttons and reads displays takes master.
interface bakery_service_ctrl_if #(
  parameter int unsigned NUM_COUNTERS = 2,
  parameter int unsigned TICKET_W     = 4
);
  logic                             arrive;
  logic [NUM_COUNTERS-1:0]          confirm;
  logic                             ticket_vld;
  logic [TICKET_W-1:0]              ticket_out;
  logic                             full;
  logic [TICKET_W-1:0]              queue_count;
  logic [NUM_COUNTERS*TICKET_W-1:0] serving_ticket;
  logic [2*NUM_COUNTERS-1:0]        state;
  logic [NUM_COUNTERS-1:0]          done;
  logic [7:0]                       served_total;

  modport slave (
    input  arrive,
    input  confirm,
    output ticket_vld,
    output ticket_out,
    output full,
    output queue_count,
    output serving_ticket,
    output state,
    output done,
    output served_total
  );

  modport master (
    output arrive,
    output confirm,
    input  ticket_vld,
    input  ticket_out,
    input  full,
    input  queue_count,
    input  serving_ticket,
    input  state,
    input  done,
    input  served_total
  );
endinterface

// File: rtl/bakery_service_ctrl.sv
// Take-a-number bakery controller: a wrapping ticket dispenser feeding NUM_COUNTERS
// independent counters, each running IDLE -> ORDER -> BAKE -> HANDOFF.
module bakery_service_ctrl #(
  parameter int unsigned NUM_COUNTERS = 2,
  parameter int unsigned TICKET_W     = 4,
  parameter int unsigned QUEUE_DEPTH  = 8,
  parameter int unsigned BAKE_CYCLES  = 4
) (
  input logic                  clk,
  input logic                  rst,
  bakery_service_ctrl_if.slave bus
);

  localparam int unsigned        BakeW    = (BAKE_CYCLES > 1) ? $clog2(BAKE_CYCLES) : 1;
  localparam logic [BakeW-1:0]    BakeLoad = BakeW'(BAKE_CYCLES - 1);
  localparam logic [TICKET_W-1:0] Depth    = TICKET_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StOrder   = 2'b01,
    StBake    = 2'b10,
    StHandoff = 2'b11
  } state_e;

  logic [TICKET_W-1:0]     r_next_ticket;
  logic [TICKET_W-1:0]     r_now_serving;
  logic [TICKET_W-1:0]     w_queue_count;
  logic                    w_full;
  logic                    w_accept;
  logic                    w_assign;
  logic                    w_found;
  logic [NUM_COUNTERS-1:0] w_idle;
  logic [NUM_COUNTERS-1:0] w_grant;
  logic [NUM_COUNTERS-1:0] w_handoff;
  logic [7:0]              w_handoff_cnt;
  logic [7:0]              r_served_total;

  state_e              r_state        [NUM_COUNTERS];
  state_e              w_state_nxt    [NUM_COUNTERS];
  logic [BakeW-1:0]    r_bake_cnt     [NUM_COUNTERS];
  logic [BakeW-1:0]    w_bake_cnt_nxt [NUM_COUNTERS];
  logic [TICKET_W-1:0] r_serving      [NUM_COUNTERS];

  // Occupancy is the modular distance between the two ticket pointers, so wrap is free.
  assign w_queue_count = r_next_ticket - r_now_serving;
  assign w_full        = (w_queue_count == Depth);
  // Full is judged on the registered count: a slot freed on this edge does not help.
  assign w_accept      = bus.arrive & ~w_full;
  assign w_assign      = (w_queue_count != '0) & (|w_idle);

  // Decode per-counter idle/handoff flags and pick the lowest-index idle counter.
  always_comb begin
    w_idle        = '0;
    w_handoff     = '0;
    w_grant       = '0;
    w_found       = 1'b0;
    w_handoff_cnt = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      w_idle[i]    = (r_state[i] == StIdle);
      w_handoff[i] = (r_state[i] == StHandoff);
      if (w_handoff[i]) begin
        w_handoff_cnt = w_handoff_cnt + 8'd1;
      end
      if (w_idle[i] && !w_found) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  // Next-state and bake down-counter for every counter FSM.
  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      w_state_nxt[i]    = r_state[i];
      w_bake_cnt_nxt[i] = r_bake_cnt[i];
      case (r_state[i])
        StIdle: begin
          if (w_assign && w_grant[i]) begin
            w_state_nxt[i] = StOrder;
          end
        end
        StOrder: begin
          if (bus.confirm[i]) begin
            w_state_nxt[i]    = StBake;
            w_bake_cnt_nxt[i] = BakeLoad;
          end
        end
        StBake: begin
          if (r_bake_cnt[i] == '0) begin
            w_state_nxt[i] = StHandoff;
          end else begin
            w_bake_cnt_nxt[i] = r_bake_cnt[i] - 1'b1;
          end
        end
        StHandoff: begin
          w_state_nxt[i] = StIdle;
        end
        default: begin
          w_state_nxt[i] = StIdle;
        end
      endcase
    end
  end

  // Counter FSM state and bake timer registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (rst) begin
        r_state[i]    <= StIdle;
        r_bake_cnt[i] <= '0;
      end else begin
        r_state[i]    <= w_state_nxt[i];
        r_bake_cnt[i] <= w_bake_cnt_nxt[i];
      end
    end
  end

  // Latch the ticket being served when a counter is assigned; held through IDLE.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (rst) begin
        r_serving[i] <= '0;
      end else if (w_assign && w_grant[i]) begin
        r_serving[i] <= r_now_serving;
      end
    end
  end

  // Ticket dispenser pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_ticket <= '0;
      r_now_serving <= '0;
    end else begin
      if (w_accept) begin
        r_next_ticket <= r_next_ticket + 1'b1;
      end
      if (w_assign) begin
        r_now_serving <= r_now_serving + 1'b1;
      end
    end
  end

  // Completed-handoff tally; several simultaneous handoffs all count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_served_total <= '0;
    end else begin
      r_served_total <= r_served_total + w_handoff_cnt;
    end
  end

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_out
    assign bus.state[2*g +: 2]                     = r_state[g];
    assign bus.serving_ticket[g*TICKET_W +: TICKET_W] = r_serving[g];
  end

  assign bus.ticket_vld   = w_accept;
  assign bus.ticket_out   = r_next_ticket;
  assign bus.full         = w_full;
  assign bus.queue_count  = w_queue_count;
  assign bus.done         = w_handoff;
  assign bus.served_total = r_served_total;

endmodule

// File: tb/tb_bakery_service_ctrl.sv
// Directed bench for bakery_service_ctrl with a queue-based reference model checked every cycle.
module tb_bakery_service_ctrl;
  localparam int NC   = 2;
  localparam int TW   = 4;
  localparam int QD   = 8;
  localparam int BK   = 4;
  localparam int TMOD = 1 << TW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bakery_service_ctrl_if #(.NUM_COUNTERS(NC), .TICKET_W(TW)) bus ();

  bakery_service_ctrl #(
    .NUM_COUNTERS(NC),
    .TICKET_W    (TW),
    .QUEUE_DEPTH (QD),
    .BAKE_CYCLES (BK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: customers waiting in a queue, each counter a phase
  // (0 idle, 1 order, 2 bake, 3 handoff) with bake cycles still to go.
  int m_next;
  int m_wait[$];
  int m_phase[NC];
  int m_tkt[NC];
  int m_left[NC];
  int m_served;
  bit m_valid = 1'b0;
  bit m_acc;
  int m_free;

  always @(posedge clk) begin
    if (rst) begin
      m_next   = 0;
      m_wait.delete();
      m_served = 0;
      for (int i = 0; i < NC; i++) begin
        m_phase[i] = 0;
        m_tkt[i]   = 0;
        m_left[i]  = 0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_acc  = bus.arrive && (m_wait.size() < QD);
      m_free = -1;
      for (int i = 0; i < NC; i++) begin
        if (m_phase[i] == 0 && m_free < 0) m_free = i;
      end
      for (int i = 0; i < NC; i++) begin
        case (m_phase[i])
          3: begin m_phase[i] = 0; m_served++; end
          2: begin m_left[i]--; if (m_left[i] == 0) m_phase[i] = 3; end
          1: if (bus.confirm[i]) begin m_phase[i] = 2; m_left[i] = BK; end
          default: ;
        endcase
      end
      if (m_free >= 0 && m_wait.size() > 0) begin
        m_phase[m_free] = 1;
        m_tkt[m_free]   = m_wait.pop_front();
      end
      if (m_acc) begin
        m_wait.push_back(m_next % TMOD);
        m_next++;
      end
    end
  end

  int e_state, e_serv, e_done;
  always @(negedge clk) begin
    if (m_valid) begin
      e_state = 0;
      e_serv  = 0;
      e_done  = 0;
      for (int i = 0; i < NC; i++) begin
        e_state = e_state | (m_phase[i] << (2 * i));
        e_serv  = e_serv | (m_tkt[i] << (TW * i));
        if (m_phase[i] == 3) e_done = e_done | (1 << i);
      end
      check("m_ticket_vld", int'(bus.ticket_vld), int'(bus.arrive && (m_wait.size() < QD)));
      check("m_ticket_out", int'(bus.ticket_out), m_next % TMOD);
      check("m_queue_count", int'(bus.queue_count), m_wait.size());
      check("m_full", int'(bus.full), int'(m_wait.size() == QD));
      check("m_state", int'(bus.state), e_state);
      check("m_serving", int'(bus.serving_ticket), e_serv);
      check("m_done", int'(bus.done), e_done);
      check("m_served_total", int'(bus.served_total), m_served % 256);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.arrive  = 1'b0;
    bus.confirm = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_state", int'(bus.state), 0);
    check("rst_queue", int'(bus.queue_count), 0);

    // Single customer
    bus.arrive = 1'b1;
    #1;
    check("single_vld", int'(bus.ticket_vld), 1);
    check("single_tkt", int'(bus.ticket_out), 0);
    tick();
    bus.arrive = 1'b0;
    check("single_q1", int'(bus.queue_count), 1);
    check("single_idle", int'(bus.state), 0);
    tick();
    check("single_order", int'(bus.state), 1);
    check("single_serv", int'(bus.serving_ticket), 0);
    check("single_q0", int'(bus.queue_count), 0);
    bus.confirm = 2'b01;
    tick();
    bus.confirm = '0;
    check("single_bake0", int'(bus.state), 2);
    repeat (3) tick();
    check("single_bake3", int'(bus.state), 2);
    tick();
    check("single_handoff", int'(bus.state), 3);
    check("single_done", int'(bus.done), 1);
    check("single_srv0", int'(bus.served_total), 0);
    tick();
    check("single_back_idle", int'(bus.state), 0);
    check("single_done_low", int'(bus.done), 0);
    check("single_srv1", int'(bus.served_total), 1);

    // Priority between counters
    do_reset();
    bus.arrive = 1'b1;
    repeat (3) tick();
    bus.arrive = 1'b0;
    tick();
    check("prio_state", int'(bus.state), 5);
    check("prio_serv", int'(bus.serving_ticket), 8'h10);
    check("prio_q", int'(bus.queue_count), 1);
    bus.confirm = 2'b01;
    tick();
    bus.confirm = '0;
    repeat (4) tick();
    check("prio_handoff", int'(bus.state), 7);
    tick();
    check("prio_idle_gap", int'(bus.state), 4);
    check("prio_q_gap", int'(bus.queue_count), 1);
    tick();
    check("prio_reassign", int'(bus.state), 5);
    check("prio_serv2", int'(bus.serving_ticket), 8'h12);
    check("prio_q0", int'(bus.queue_count), 0);

    // Full queue
    do_reset();
    bus.arrive = 1'b1;
    repeat (10) tick();
    #1;
    check("full_flag", int'(bus.full), 1);
    check("full_q", int'(bus.queue_count), 8);
    check("full_rej", int'(bus.ticket_vld), 0);
    check("full_tkt", int'(bus.ticket_out), 10);
    tick();
    check("full_q_hold", int'(bus.queue_count), 8);
    check("full_tkt_hold", int'(bus.ticket_out), 10);
    bus.confirm = 2'b01;
    tick();
    bus.confirm = '0;
    repeat (5) tick();
    #1;
    check("full_idle", int'(bus.state), 4);
    check("full_same_edge_rej", int'(bus.ticket_vld), 0);
    tick();
    #1;
    check("full_q7", int'(bus.queue_count), 7);
    check("full_tkt_kept", int'(bus.ticket_out), 10);
    check("full_accept_again", int'(bus.ticket_vld), 1);
    check("full_serv", int'(bus.serving_ticket), 8'h12);
    bus.arrive = 1'b0;
    tick();

    // Ticket wrap with continuous service
    do_reset();
    bus.confirm = 2'b11;
    for (int i = 0; i < 17; i++) begin
      bus.arrive = 1'b1;
      #1;
      check("wrap_vld", int'(bus.ticket_vld), 1);
      check("wrap_tkt", int'(bus.ticket_out), i % 16);
      tick();
      bus.arrive = 1'b0;
      repeat (3) tick();
    end
    repeat (20) tick();
    bus.confirm = '0;
    check("wrap_q0", int'(bus.queue_count), 0);
    check("wrap_served", int'(bus.served_total), 17);
    check("wrap_idle", int'(bus.state), 0);

    // Stray confirms
    do_reset();
    bus.confirm = 2'b10;
    tick();
    bus.confirm = '0;
    check("stray_idle", int'(bus.state), 0);
    bus.arrive = 1'b1;
    tick();
    tick();
    bus.arrive = 1'b0;
    tick();
    check("stray_both_order", int'(bus.state), 5);
    bus.confirm = 2'b10;
    tick();
    tick();
    tick();
    bus.confirm = '0;
    tick();
    check("stray_bake4", int'(bus.state), 9);
    tick();
    check("stray_handoff", int'(bus.state), 13);
    check("stray_done", int'(bus.done), 2);
    tick();
    check("stray_srv", int'(bus.served_total), 1);

    // Reset in the middle of BAKE with a ticket queued
    bus.confirm = 2'b01;
    tick();
    bus.confirm = '0;
    bus.arrive  = 1'b1;
    tick();
    bus.arrive = 1'b0;
    check("mid_bake", int'(bus.state) & 3, 2);
    check("mid_q", int'(bus.queue_count), 1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("mrst_state", int'(bus.state), 0);
    check("mrst_q", int'(bus.queue_count), 0);
    check("mrst_srv", int'(bus.served_total), 0);
    check("mrst_done", int'(bus.done), 0);
    check("mrst_serv", int'(bus.serving_ticket), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bakery_service_ctrl.md
# bakery_service_ctrl

Parametrised multi-counter bakery controller. It extends the single-customer TURN/ORDER/WAIT flow into a take-a-number ticket queue served by NUM_COUNTERS independent counter state machines, each with a timed bake phase and a handoff pulse. It sits between the customer-arrival and order-confirm push buttons and the board's per-counter status LEDs and 7-segment ticket displays.

## Interface

Parameters:
- NUM_COUNTERS, 2, number of service counters (1..4).
- TICKET_W, 4, ticket number width; tickets wrap modulo 2^TICKET_W.
- QUEUE_DEPTH, 8, maximum waiting customers; must satisfy 1 <= QUEUE_DEPTH < 2^TICKET_W.
- BAKE_CYCLES, 4, cycles spent in BAKE (>= 1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- arrive  in  1  customer requests a ticket this cycle.
- confirm  in  NUM_COUNTERS  bit i: order confirmed at counter i.
- ticket_vld  out  1  arrive accepted this cycle.
- ticket_out  out  TICKET_W  ticket issued this cycle; valid when ticket_vld = 1.
- full  out  1  queue_count == QUEUE_DEPTH.
- queue_count  out  TICKET_W  tickets issued but not yet assigned to a counter.
- serving_ticket  out  NUM_COUNTERS*TICKET_W  slice i: ticket held by counter i.
- state  out  2*NUM_COUNTERS  slice i: counter i state code.
- done  out  NUM_COUNTERS  bit i high while counter i is in HANDOFF.
- served_total  out  8  count of completed handoffs; wraps at 255 -> 0.

## Operation

- Ticket dispenser: registers next_ticket and now_serving, both TICKET_W bits, both wrapping. queue_count = next_ticket - now_serving (mod 2^TICKET_W).
- Accept: ticket_vld = arrive & ~full (combinational). ticket_out = next_ticket. On an accepting edge, next_ticket increments.
- Per-counter Moore FSM, codes IDLE=00, ORDER=01, BAKE=10, HANDOFF=11:
  - IDLE -> ORDER when the counter is selected for assignment.
  - ORDER -> BAKE on confirm[i]; otherwise stays in ORDER, with no timeout.
  - BAKE -> HANDOFF after exactly BAKE_CYCLES cycles in BAKE, using a per-counter down-counter loaded with BAKE_CYCLES-1 on entry.
  - HANDOFF -> IDLE unconditionally after 1 cycle.
- Assignment: on each edge where queue_count > 0 and at least one counter is IDLE, the lowest-index IDLE counter enters ORDER and latches serving_ticket = now_serving, and now_serving increments. At most one assignment occurs per cycle.
- confirm[i] is ignored in any state other than ORDER.
- served_total increments once for each cycle in which a counter is in HANDOFF. If k counters are in HANDOFF in the same cycle, it adds k.
- serving_ticket holds its value through IDLE until the counter is reassigned.

## Timing

- Reset values: every state slice IDLE, serving_ticket 0, next_ticket 0, now_serving 0, queue_count 0, full 0, done 0, served_total 0.
- ticket_vld and ticket_out are 0-cycle combinational from arrive and the registered count. All other outputs are registered (Moore).
- Arrive into an empty queue: queue_count becomes 1 after edge E. Assignment happens at the earliest on edge E+1, so ORDER is visible one cycle after queue_count = 1.
- An accept and an assignment on the same edge leave queue_count unchanged.
- full is evaluated from the registered count. An arrive while full is rejected (ticket_vld = 0) even if an assignment frees a slot on that edge.
- A counter spends at least 1 cycle in IDLE after HANDOFF before it can be reassigned.
- Confirm-to-done latency: ORDER with confirm at edge E gives BAKE for cycles E..E+BAKE_CYCLES-1 and HANDOFF in the following cycle.
- Ticket wrap: the ticket after 2^TICKET_W-1 is 0. queue_count stays correct across the wrap.
- rst asserted mid-operation: on that edge all state returns to reset values, and queued tickets and in-progress orders are discarded.

## Test plan

- Reset: hold rst 2 cycles mid-BAKE -> every state slice 00, queue_count 0, served_total 0, done 0.
- Single customer (defaults): arrive 1 cycle -> ticket_out 0, ticket_vld 1; next cycle queue_count 1; next cycle counter 0 in ORDER with serving_ticket 0, queue_count 0; confirm[0] -> BAKE for 4 cycles, then done[0] high 1 cycle, served_total 1, then IDLE.
- Priority: 3 arrivals back-to-back with both counters IDLE -> counter 0 gets ticket 0, counter 1 gets ticket 1 one cycle later, ticket 2 stays queued (queue_count 1) until a counter returns to IDLE.
- Full: 8 arrivals with counters blocked in ORDER (no confirm) -> full 1, queue_count 8; 9th arrive gives ticket_vld 0 and next_ticket unchanged; same-cycle arrive plus assignment when full -> still rejected.
- Wrap: issue and serve 17 tickets -> ticket_out sequence 0..15, 0; queue_count never exceeds QUEUE_DEPTH and returns to 0.
- Stray confirm: confirm[1] while counter 1 is IDLE or in BAKE -> no state change and BAKE duration unchanged at 4 cycles.
